// File: rtl/ws2811_stream_encoder_pkg.sv
// rtl/ws2811_stream_encoder_pkg.sv - shared timing defaults, state encoding and helpers
//
// Purpose: default WS2811 timing constants (800 kbps at a 50 MHz masterClk) and
// the encoder state encoding shared by the top and the bit timer.
// Ports: none (package).
package ws2811_stream_encoder_pkg;

  localparam int WS2811_WORD_W    = 24;
  localparam int WS2811_BIT_CYC   = 62;
  localparam int WS2811_T0H_CYC   = 12;
  localparam int WS2811_T1H_CYC   = 30;
  localparam int WS2811_LATCH_CYC = 2600;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BIT   = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ws2811_bit_timer.sv
// rtl/ws2811_bit_timer.sv - one WS2811 bit period: line level and end-of-bit strobe
//
// Purpose: times a single bit period. A start pulse (re)loads the cycle counter
// so the period begins on the following cycle; a start in the end-of-bit cycle
// chains the next period with no gap.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       begin a bit period on the next cycle
//   bit_val     value of the bit being sent (held stable by the caller for the period)
//   slow        1 = doubled timing (400 kbps), held stable for the period
//   level       modulated line level
//   bit_end     high in the last cycle of the period
module ws2811_bit_timer #(
  parameter int BIT_CYC = 62,
  parameter int T0H_CYC = 12,
  parameter int T1H_CYC = 30,
  parameter int CNT_W   = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_val,
  input  logic slow,
  output logic level,
  output logic bit_end
);

  localparam logic [CNT_W-1:0] LAST_F = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] LAST_S = CNT_W'(2 * BIT_CYC - 1);
  localparam logic [CNT_W-1:0] T0_F   = CNT_W'(T0H_CYC);
  localparam logic [CNT_W-1:0] T0_S   = CNT_W'(2 * T0H_CYC);
  localparam logic [CNT_W-1:0] T1_F   = CNT_W'(T1H_CYC);
  localparam logic [CNT_W-1:0] T1_S   = CNT_W'(2 * T1H_CYC);

  logic             active;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last_cnt;
  logic [CNT_W-1:0] high_cnt;

  always_comb begin
    last_cnt = slow ? LAST_S : LAST_F;
    high_cnt = bit_val ? (slow ? T1_S : T1_F) : (slow ? T0_S : T0_F);
  end

  assign level   = active && (cnt < high_cnt);
  assign bit_end = active && (cnt == last_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
    end else if (bit_end) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (active) begin
      cnt    <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ws2811_stream_encoder.sv
// rtl/ws2811_stream_encoder.sv - pixel-word stream to WS2811 line encoder
//
// Purpose: accepts whole pixel words over a valid/ready handshake and sends them
// MSB-first on the WS2811 line, chaining words gaplessly and inserting the latch
// low gap after a word flagged last.
// Optional feature macro: WS2811_SLOW_MODE_EN (adds speedSel, 400 kbps timing).
// Ports:
//   masterClk    master clock
//   nReset       asynchronous active-low reset
//   dataIn       pixel word, MSB first
//   dataValid    dataIn/lastIn valid
//   lastIn       word is last of frame (latch gap follows)
//   dataReady    word accepted when dataValid && dataReady
//   dataOut      modulated WS2811 line
//   busy         not IDLE
//   underrun     sticky: a non-last word ended with no successor
//   clrUnderrun  synchronous clear of underrun (a simultaneous set wins)
//   speedSel     (WS2811_SLOW_MODE_EN only) 1 = 400 kbps, sampled per word
module ws2811_stream_encoder
  import ws2811_stream_encoder_pkg::*;
#(
  parameter int WORD_W    = WS2811_WORD_W,
  parameter int BIT_CYC   = WS2811_BIT_CYC,
  parameter int T0H_CYC   = WS2811_T0H_CYC,
  parameter int T1H_CYC   = WS2811_T1H_CYC,
  parameter int LATCH_CYC = WS2811_LATCH_CYC
) (
  input  logic              masterClk,
  input  logic              nReset,
  input  logic [WORD_W-1:0] dataIn,
  input  logic              dataValid,
  input  logic              lastIn,
  output logic              dataReady,
  output logic              dataOut,
  output logic              busy,
  output logic              underrun,
  input  logic              clrUnderrun
`ifdef WS2811_SLOW_MODE_EN
  ,
  input  logic              speedSel
`endif
);

`ifdef WS2811_SLOW_MODE_EN
  localparam int CNT_W = $clog2(max_int(2 * BIT_CYC, LATCH_CYC));
`else
  localparam int CNT_W = $clog2(max_int(BIT_CYC, LATCH_CYC));
`endif
  localparam int IDX_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYC - 1);

  if (!(WORD_W >= 8 && WORD_W <= 32 && T0H_CYC > 0 && T0H_CYC < T1H_CYC &&
        T1H_CYC < BIT_CYC && LATCH_CYC > BIT_CYC)) begin : g_param_check
    $error("ws2811_stream_encoder: illegal WORD_W or timing parameters");
  end

  state_t            state;
  state_t            state_nx;
  logic              run_q;      // holds dataReady low until the first cycle after reset release
  logic [WORD_W-1:0] shift_reg;
  logic [IDX_W-1:0]  bit_idx;
  logic              last_flag;
  logic [CNT_W-1:0]  lat_cnt;
  logic              accept;
  logic              word_end;
  logic              lat_done;
  logic              tmr_start;
  logic              tmr_level;
  logic              tmr_end;
  logic              tmr_slow;

  assign accept    = dataValid && dataReady;
  assign word_end  = (state == ST_BIT) && tmr_end && (bit_idx == '0);
  assign lat_done  = (state == ST_LATCH) && (lat_cnt == LATCH_LAST);
  assign tmr_start = accept || ((state == ST_BIT) && tmr_end && (bit_idx != '0));
  assign dataOut   = tmr_level;

`ifdef WS2811_SLOW_MODE_EN
  logic speed_q;
  always_ff @(posedge masterClk or negedge nReset) begin
    if (!nReset) begin
      speed_q <= 1'b0;
    end else if (accept) begin
      speed_q <= speedSel;
    end
  end
  assign tmr_slow = speed_q;
`else
  assign tmr_slow = 1'b0;
`endif

  ws2811_bit_timer #(
    .BIT_CYC (BIT_CYC),
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .CNT_W   (CNT_W)
  ) u_bit_timer (
    .clk     (masterClk),
    .rst_n   (nReset),
    .start   (tmr_start),
    .bit_val (shift_reg[WORD_W-1]),
    .slow    (tmr_slow),
    .level   (tmr_level),
    .bit_end (tmr_end)
  );

  always_ff @(posedge masterClk or negedge nReset) begin
    if (!nReset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (accept) state_nx = ST_BIT;
      ST_BIT: begin
        if (word_end) begin
          if (accept)         state_nx = ST_BIT;
          else if (last_flag) state_nx = ST_LATCH;
          else                state_nx = ST_IDLE;
        end
      end
      ST_LATCH: if (lat_done) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != ST_IDLE);
    dataReady = 1'b0;
    case (state)
      ST_IDLE: dataReady = run_q;
      ST_BIT:  dataReady = word_end && !last_flag;
      default: dataReady = 1'b0;
    endcase
  end

  always_ff @(posedge masterClk or negedge nReset) begin
    if (!nReset) begin
      run_q     <= 1'b0;
      shift_reg <= '0;
      bit_idx   <= '0;
      last_flag <= 1'b0;
      lat_cnt   <= '0;
      underrun  <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (accept) begin
        shift_reg <= dataIn;
        last_flag <= lastIn;
        bit_idx   <= IDX_W'(WORD_W - 1);
      end else if (tmr_start) begin
        shift_reg <= {shift_reg[WORD_W-2:0], 1'b0};
        bit_idx   <= bit_idx - IDX_W'(1);
      end

      if (state != ST_LATCH) begin
        lat_cnt <= '0;
      end else if (!lat_done) begin
        lat_cnt <= lat_cnt + CNT_W'(1);
      end

      if (word_end && !accept && !last_flag) begin
        underrun <= 1'b1;
      end else if (clrUnderrun) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule
